fetch_decode: RTL

Front-end stage of the 16-bit CPU: fetches instruction words from instruction memory via a request/acknowledge handshake, decodes the 5-bit opcode and register/immediate fields, and presents one decoded instruction per handshake to the execute stage (ALU, register file, branch unit). Execute redirects the program counter on taken branches; fetch discards any wrong-path work.

---
 rtl/cpu_pkg.sv | 80 ++++++++
 rtl/fetch_decode_if.sv | 40 ++++
 rtl/fetch_decode_instr_decoder.sv | 70 +++++++
 rtl/fetch_decode.sv | 104 ++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: instruction field layout, opcode and ALU op encodings,
// and the decoded-instruction bundle passed from fetch/decode to execute.
package cpu_pkg;

    localparam int unsigned DataW  = 16;
    localparam int unsigned RegW   = 3;
    localparam int unsigned AluW   = 4;
    localparam int unsigned OpW    = 5;

    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 11;
    localparam int unsigned RdMsb  = 10;
    localparam int unsigned RdLsb  = 8;
    localparam int unsigned RaMsb  = 7;
    localparam int unsigned RaLsb  = 5;
    localparam int unsigned RbMsb  = 4;
    localparam int unsigned RbLsb  = 2;
    localparam int unsigned Imm5W  = 5;
    localparam int unsigned Imm11W = 11;

    typedef logic [OpW-1:0]   opcode_t;
    typedef logic [AluW-1:0]  alu_op_t;
    typedef logic [RegW-1:0]  reg_idx_t;
    typedef logic [DataW-1:0] word_t;

    localparam opcode_t OP_ADD  = 5'd0;
    localparam opcode_t OP_SUB  = 5'd1;
    localparam opcode_t OP_OR   = 5'd2;
    localparam opcode_t OP_AND  = 5'd3;
    localparam opcode_t OP_XOR  = 5'd4;
    localparam opcode_t OP_SL   = 5'd5;
    localparam opcode_t OP_SR   = 5'd6;
    localparam opcode_t OP_ADDI = 5'd7;
    localparam opcode_t OP_SUBI = 5'd8;
    localparam opcode_t OP_ORI  = 5'd9;
    localparam opcode_t OP_ANDI = 5'd10;
    localparam opcode_t OP_XORI = 5'd11;
    localparam opcode_t OP_SLI  = 5'd12;
    localparam opcode_t OP_SRI  = 5'd13;
    localparam opcode_t OP_BR   = 5'd14;
    localparam opcode_t OP_GT   = 5'd15;
    localparam opcode_t OP_LT   = 5'd16;
    localparam opcode_t OP_EQ   = 5'd17;
    localparam opcode_t OP_STW  = 5'd18;
    localparam opcode_t OP_LDW  = 5'd19;

    localparam alu_op_t ALU_ADD = 4'd0;
    localparam alu_op_t ALU_SUB = 4'd1;
    localparam alu_op_t ALU_OR  = 4'd2;
    localparam alu_op_t ALU_AND = 4'd3;
    localparam alu_op_t ALU_XOR = 4'd4;
    localparam alu_op_t ALU_SL  = 4'd5;
    localparam alu_op_t ALU_SR  = 4'd6;
    localparam alu_op_t ALU_GT  = 4'd7;
    localparam alu_op_t ALU_LT  = 4'd8;
    localparam alu_op_t ALU_EQ  = 4'd9;

    typedef struct packed {
        alu_op_t  alu_op;
        reg_idx_t rd;
        reg_idx_t ra;
        reg_idx_t rb;
        word_t    imm;
        logic     use_imm;
        logic     wb_en;
        logic     is_branch;
        logic     is_load;
        logic     is_store;
        logic     illegal;
    } dec_t;

    function automatic word_t sext5(input logic [Imm5W-1:0] v);
        return {{(DataW - Imm5W){v[Imm5W-1]}}, v};
    endfunction

    function automatic word_t sext11(input logic [Imm11W-1:0] v);
        return {{(DataW - Imm11W){v[Imm11W-1]}}, v};
    endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Signals between fetch/decode, instruction memory and the execute stage.
interface fetch_decode_if;
    import cpu_pkg::*;

    logic     imem_req;
    word_t    imem_addr;
    logic     imem_ack;
    word_t    imem_rdata;
    logic     redirect_valid;
    word_t    redirect_pc;
    logic     dec_valid;
    logic     dec_ready;
    word_t    dec_pc;
    alu_op_t  dec_alu_op;
    reg_idx_t dec_rd;
    reg_idx_t dec_ra;
    reg_idx_t dec_rb;
    word_t    dec_imm;
    logic     dec_use_imm;
    logic     dec_wb_en;
    logic     dec_is_branch;
    logic     dec_is_load;
    logic     dec_is_store;
    logic     dec_illegal;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_pc, dec_alu_op, dec_rd, dec_ra, dec_rb,
               dec_imm, dec_use_imm, dec_wb_en, dec_is_branch, dec_is_load, dec_is_store,
               dec_illegal,
        input  imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_pc, dec_alu_op, dec_rd, dec_ra, dec_rb,
               dec_imm, dec_use_imm, dec_wb_en, dec_is_branch, dec_is_load, dec_is_store,
               dec_illegal,
        output imem_ack, imem_rdata, redirect_valid, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_decode_instr_decoder.sv
// Combinational instruction decoder: one 16-bit instruction word to a decoded bundle.
module instr_decoder
    import cpu_pkg::*;
(
    input  word_t instr,
    output dec_t  dec
);

    opcode_t           op;
    logic [OpW-1:0]    imm_op_off;

    assign op         = instr[OpMsb:OpLsb];
    assign imm_op_off = op - OP_ADDI;

    always_comb begin
        dec        = '0;
        dec.alu_op = ALU_ADD;
        // Register fields are always extracted; execute ignores the ones a class does not use.
        dec.rd     = instr[RdMsb:RdLsb];
        dec.ra     = instr[RaMsb:RaLsb];
        dec.rb     = instr[RbMsb:RbLsb];
        case (op)
            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_SL, OP_SR: begin
                dec.alu_op = op[AluW-1:0];
                dec.wb_en  = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                dec.alu_op  = imm_op_off[AluW-1:0];
                dec.use_imm = 1'b1;
                dec.wb_en   = 1'b1;
                dec.imm     = sext5(instr[Imm5W-1:0]);
            end
            OP_ORI, OP_ANDI, OP_XORI, OP_SLI, OP_SRI: begin
                dec.alu_op  = imm_op_off[AluW-1:0];
                dec.use_imm = 1'b1;
                dec.wb_en   = 1'b1;
                dec.imm     = {{(DataW - Imm5W){1'b0}}, instr[Imm5W-1:0]};
            end
            OP_BR: begin
                dec.is_branch = 1'b1;
                dec.imm       = sext11(instr[Imm11W-1:0]);
            end
            OP_GT: begin
                dec.alu_op = ALU_GT;
                dec.wb_en  = 1'b1;
            end
            OP_LT: begin
                dec.alu_op = ALU_LT;
                dec.wb_en  = 1'b1;
            end
            OP_EQ: begin
                dec.alu_op = ALU_EQ;
                dec.wb_en  = 1'b1;
            end
            OP_STW: begin
                dec.is_store = 1'b1;
                dec.use_imm  = 1'b1;
                dec.imm      = sext5(instr[Imm5W-1:0]);
            end
            OP_LDW: begin
                dec.is_load = 1'b1;
                dec.use_imm = 1'b1;
                dec.wb_en   = 1'b1;
                dec.imm     = sext5(instr[Imm5W-1:0]);
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode front end: request/ack instruction fetch, decode, and a held decoded instruction
// for execute, with branch redirect that discards wrong-path fetches.
module fetch_decode
    import cpu_pkg::*;
(
    input logic            clk,
    input logic            reset,
    fetch_decode_if.master bus
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_t;

    state_t state;
    word_t  pc;          // next sequential fetch address (or pending redirect target)
    word_t  fetch_addr;  // address of the outstanding request, stable while imem_req is high
    logic   kill;
    logic   req;
    logic   dec_valid;
    word_t  dec_pc;
    dec_t   dec_q;
    dec_t   dec_next;
    word_t  fetch_addr_inc;

    instr_decoder u_instr_decoder (
        .instr (bus.imem_rdata),
        .dec   (dec_next)
    );

    assign fetch_addr_inc = fetch_addr + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            pc         <= '0;
            fetch_addr <= '0;
            kill       <= 1'b0;
            req        <= 1'b0;
            dec_valid  <= 1'b0;
            dec_pc     <= '0;
            dec_q      <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    state      <= StFetch;
                    req        <= 1'b1;
                    fetch_addr <= bus.redirect_valid ? bus.redirect_pc : pc;
                    pc         <= bus.redirect_valid ? bus.redirect_pc : pc;
                end
                StFetch: begin
                    if (bus.imem_ack) begin
                        if (kill || bus.redirect_valid) begin
                            // Wrong-path word: drop it and re-request at the redirect target.
                            kill       <= 1'b0;
                            fetch_addr <= bus.redirect_valid ? bus.redirect_pc : pc;
                            pc         <= bus.redirect_valid ? bus.redirect_pc : pc;
                        end else begin
                            dec_q     <= dec_next;
                            dec_pc    <= fetch_addr;
                            dec_valid <= 1'b1;
                            pc        <= fetch_addr_inc;
                            req       <= 1'b0;
                            state     <= StHold;
                        end
                    end else if (bus.redirect_valid) begin
                        pc   <= bus.redirect_pc;
                        kill <= 1'b1;
                    end
                end
                StHold: begin
                    if (bus.redirect_valid) begin
                        pc         <= bus.redirect_pc;
                        fetch_addr <= bus.redirect_pc;
                        dec_valid  <= 1'b0;
                        req        <= 1'b1;
                        state      <= StFetch;
                    end else if (bus.dec_ready) begin
                        fetch_addr <= pc;
                        dec_valid  <= 1'b0;
                        req        <= 1'b1;
                        state      <= StFetch;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.imem_req      = req;
    assign bus.imem_addr     = fetch_addr;
    assign bus.dec_valid     = dec_valid;
    assign bus.dec_pc        = dec_pc;
    assign bus.dec_alu_op    = dec_q.alu_op;
    assign bus.dec_rd        = dec_q.rd;
    assign bus.dec_ra        = dec_q.ra;
    assign bus.dec_rb        = dec_q.rb;
    assign bus.dec_imm       = dec_q.imm;
    assign bus.dec_use_imm   = dec_q.use_imm;
    assign bus.dec_wb_en     = dec_q.wb_en;
    assign bus.dec_is_branch = dec_q.is_branch;
    assign bus.dec_is_load   = dec_q.is_load;
    assign bus.dec_is_store  = dec_q.is_store;
    assign bus.dec_illegal   = dec_q.illegal;

endmodule
